ex_muldiv_unit: RTL and testbench

- EX-stage iterative multiply/divide unit, directly downstream of the ALU-source mux.
- Operand A is ReadData1; operand B is the ALU-source mux output (sign-extended immediate or ReadData2).
- Implements MULT/MULTU/DIV/DIVU into architectural HI/LO registers and supports MTHI/MTLO and the reads used by MFHI/MFLO.
- Raises a stall toward the hazard unit while an operation is in flight and a dependent instruction arrives.

---
 rtl/mips_pkg.sv | 19 +
 rtl/md_sign_fix.sv | 12 +
 rtl/ex_muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the EX-stage multiply/divide unit
package mips_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// rtl/md_sign_fix.sv - conditional two's-complement negate (abs of operands, sign fix of results)
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? ((~val) + W'(1)) : val;

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU into HI/LO with MTHI/MTLO and hazard stall
module ex_muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int ITER  = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             flush,
    input  logic             hilo_rd,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CNT_W = $clog2(ITER + 1);

    md_state_e          state_q, state_d;
    md_op_e             op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rsign_q, rsign_d, dsign_q, dsign_d;
    logic               divz_q, divz_d, done_q, done_d;

    logic               a_neg, b_neg, signed_q;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_res, rem_res, rem_src;
    logic [2*WIDTH-1:0] prod_res, mul_next, div_next;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;

    assign a_neg    = ~op[0] & opA[WIDTH-1];
    assign b_neg    = ~op[0] & opB[WIDTH-1];
    assign signed_q = ~op_q[0];

    md_sign_fix #(.W(WIDTH)) u_abs_a (.val(opA), .neg(a_neg), .res(a_mag));
    md_sign_fix #(.W(WIDTH)) u_abs_b (.val(opB), .neg(b_neg), .res(b_mag));

    // acc holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    assign mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // a zero divisor freezes acc, so its low half still holds |A| and sign fix restores A
    assign rem_src = divz_q ? acc_q[WIDTH-1:0] : acc_q[2*WIDTH-1:WIDTH];

    md_sign_fix #(.W(2*WIDTH)) u_fix_prod (.val(acc_q), .neg(signed_q & rsign_q), .res(prod_res));
    md_sign_fix #(.W(WIDTH)) u_fix_quo (.val(acc_q[WIDTH-1:0]), .neg(signed_q & rsign_q), .res(quo_res));
    md_sign_fix #(.W(WIDTH)) u_fix_rem (.val(rem_src), .neg(signed_q & dsign_q), .res(rem_res));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        rsign_d = rsign_q;
        dsign_d = dsign_q;
        divz_d  = divz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d    = md_op_e'(op);
                    acc_d   = {{WIDTH{1'b0}}, a_mag};
                    b_d     = b_mag;
                    cnt_d   = '0;
                    rsign_d = opA[WIDTH-1] ^ opB[WIDTH-1];
                    dsign_d = opA[WIDTH-1];
                    divz_d  = op[1] & (opB == '0);
                    state_d = S_RUN;
                end else if (!start) begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!divz_q) acc_d = op_q[1] ? div_next : mul_next;
                    if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    if (op_q[1]) begin
                        lo_d = divz_q ? '1 : quo_res;
                        hi_d = rem_res;
                    end else begin
                        {hi_d, lo_d} = prod_res;
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= MD_MULT;
            acc_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            rsign_q <= 1'b0;
            dsign_q <= 1'b0;
            divz_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            rsign_q <= rsign_d;
            dsign_q <= dsign_d;
            divz_q  <= divz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign done  = done_q;
    assign busy  = (state_q != S_IDLE);
    assign stall = busy & (start | hilo_rd | hi_we | lo_we);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit against an arithmetic reference
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic        flush = 1'b0;
    logic        hilo_rd = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int errors = 0;
    int checks = 0;

    ex_muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opA(opA), .opB(opB),
        .flush(flush), .hilo_rd(hilo_rd), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] rh, output logic [31:0] rl);
        longint sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        rh = '0;
        rl = '0;
        case (o)
            2'b00: begin sp = sa * sb; {rh, rl} = sp; end
            2'b01: begin up = ua * ub; {rh, rl} = up; end
            default: begin
                if (b == 0) begin
                    rl = 32'hFFFF_FFFF;
                    rh = a;
                end else if (o == 2'b10) begin
                    rl = 32'(sa / sb);
                    rh = 32'(sa % sb);
                end else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] eh, el;
        int edges, busy_cyc;
        ref_model(o, a, b, eh, el);
        op = o; opA = a; opB = b; start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_cyc++;
            tick();
            edges++;
        end
        check_eq({tag, " latency"}, 64'(edges), 64'd33);
        check_eq({tag, " busy_cycles"}, 64'(busy_cyc), 64'd33);
        check_eq({tag, " hi"}, 64'(hi), 64'(eh));
        check_eq({tag, " lo"}, 64'(lo), 64'(el));
        check_eq({tag, " busy_after"}, 64'(busy), 64'd0);
        tick();
        check_eq({tag, " done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int stall_cnt, edges, done_cnt;

        #2;
        check_eq("rst hi", 64'(hi), 64'd0);
        check_eq("rst lo", 64'(lo), 64'd0);
        check_eq("rst busy", 64'(busy), 64'd0);
        check_eq("rst done", 64'(done), 64'd0);
        check_eq("rst stall", 64'(stall), 64'd0);
        #10;
        rst_n = 1'b1;
        tick();

        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5;
        #1;
        check_eq("idle mt stall", 64'(stall), 64'd0);
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        check_eq("mt both hi", 64'(hi), 64'hA5);
        check_eq("mt both lo", 64'(lo), 64'hA5);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, "mult -3*5");
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, "multu");
        run_op(2'b11, 32'd100, 32'd7, "divu 100/7");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        run_op(2'b10, 32'd7, 32'd0, "div by zero");
        run_op(2'b11, 32'hDEAD_BEEF, 32'd0, "divu by zero");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div minneg");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult minneg");
        run_op(2'b10, 32'h8000_0000, 32'd0, "div minneg/0");

        for (int i = 0; i < 16; i++) begin
            run_op(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), "random");
        end

        op = 2'b00; opA = 32'd6; opB = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        start = 1'b1; op = 2'b11; opA = 32'd9; opB = 32'd3; hilo_rd = 1'b1;
        #1;
        stall_cnt = 0;
        edges = 5;
        while (done !== 1'b1 && edges < 45) begin
            if (stall === 1'b1) stall_cnt++;
            tick();
            edges++;
        end
        check_eq("busy start stall_cycles", 64'(stall_cnt), 64'd28);
        check_eq("busy start latency", 64'(edges), 64'd33);
        check_eq("busy start hi", 64'(hi), 64'd0);
        check_eq("busy start lo", 64'(lo), 64'd42);
        check_eq("busy start stall_end", 64'(stall), 64'd0);
        start = 1'b0; hilo_rd = 1'b0;
        run_op(2'b11, 32'd9, 32'd3, "re-presented divu");

        hi_we = 1'b1; wdata = 32'h11;
        tick();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        tick();
        lo_we = 1'b0;
        op = 2'b10; opA = 32'd1000; opB = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        hi_we = 1'b1; wdata = 32'hDEAD;
        #1;
        check_eq("mt busy stall", 64'(stall), 64'd1);
        tick();
        hi_we = 1'b0;
        check_eq("mt busy ignored", 64'(hi), 64'h11);
        repeat (6) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush busy", 64'(busy), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_cnt++;
            tick();
        end
        check_eq("flush no done", 64'(done_cnt), 64'd0);
        check_eq("flush hi", 64'(hi), 64'h11);
        check_eq("flush lo", 64'(lo), 64'h22);

        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, "multu pre-reset");
        op = 2'b00; opA = 32'd123; opB = 32'd456; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async rst hi", 64'(hi), 64'd0);
        check_eq("async rst lo", 64'(lo), 64'd0);
        check_eq("async rst busy", 64'(busy), 64'd0);
        check_eq("async rst done", 64'(done), 64'd0);
        #3;
        rst_n = 1'b1;
        tick();
        lo_we = 1'b1; wdata = 32'h5;
        tick();
        lo_we = 1'b0;
        check_eq("post rst mtlo", 64'(lo), 64'h5);
        check_eq("post rst hi", 64'(hi), 64'h0);
        check_eq("post rst busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
